mile_bcd_counter: RTL and testbench
===================================

Name: mile_bcd_counter

Overview:
- Upstream feeder of the VGA status display.
- Accumulates distance while the car is powered and moving, and presents it as a 3-digit packed BCD mileage word.
- The VGA stage consumes `mile[11:8]` (hundreds), `mile[7:4]` (tens) and `mile[3:0]` (units) directly as per-digit glyph codes.
- A cycle prescaler converts drive time into distance units.

Parameters:
- UNIT_CYCLES, 100000000, clk cycles of driving per one mileage unit (minimum 2).
- PRE_W, 27, prescaler counter width; must satisfy 2^PRE_W > UNIT_CYCLES-1.

Ports:
- clk  input  1  system clock (same clk as the VGA stage)
- rst  input  1  asynchronous reset, active-low
- power  input  1  car power; 0 = off
- mode  input  2  drive mode; 2'b00 = not in drive, any other value = drive mode
- moving  input  1  1 while the car is actually travelling (forward/back/turning)
- clear  input  1  synchronous mileage clear, active-high
- mile  output  12  packed BCD mileage {hundreds, tens, units}, each nibble 0..9
- mile_tick  output  1  one-cycle pulse on every mileage increment
- mile_wrap  output  1  one-cycle pulse when mileage wraps 999 -> 000

Behaviour:
- Reset (rst=0, async): mile=12'h000, mile_tick=0, mile_wrap=0, prescaler=0. All are registered outputs.
- count_en = power & moving & (mode != 2'b00).
- Priority, highest first: rst, then power=0, then clear, then counting.
- power=0: mile, prescaler, mile_tick and mile_wrap are all cleared on the next edge. Mileage does not survive power-off.
- clear=1 with power=1: mile=000 and prescaler=0 on the next edge. No tick is produced even if the prescaler was at terminal count. clear has priority over a simultaneous increment.
- Prescaler:
  - While count_en=1: increments each cycle.
  - When it equals UNIT_CYCLES-1 with count_en=1, it returns to 0 and an increment request is generated that same cycle.
  - While count_en=0 with power=1: it holds its value (partial distance is retained across stops).
- Increment, applied on the edge where the request is present:
  - Units+1. If units was 9: units=0, tens+1.
  - If tens was also 9: tens=0, hundreds+1.
  - If hundreds was also 9: all digits go to 0 (wrap).
  - Pure BCD carry; no nibble ever holds A..F.
- mile_tick=1 for exactly the cycle after an increment edge, coincident with the updated mile value. Otherwise 0.
- mile_wrap=1 in the same cycle as mile_tick when the update was 999 -> 000. Otherwise 0.
- Latency:
  - From count_en rising with prescaler=0, the first mile update occurs UNIT_CYCLES edges later.
  - With continuous count_en, increments occur every UNIT_CYCLES cycles.
- moving or mode toggling exactly on the terminal-count cycle: an increment occurs only if count_en=1 on that edge.
- Inputs are already synchronous to clk; no internal synchronisers.
- mile changes only on clk edges; the downstream VGA sampling glitch is not this block's concern.

Test Plan (UNIT_CYCLES=4):
- Reset then power=1, mode=01, moving=1 -> mile stays 000 for 3 edges; on the 4th edge mile=001 and mile_tick pulses 1 cycle; at 8 edges mile=002.
- Run continuously from 000 through 009 -> 010 and through 099 -> 100 -> no A..F nibble ever appears; each step is accompanied by exactly one mile_tick.
- Run to 999, continue one unit -> mile=000, mile_tick=1 and mile_wrap=1 in the same cycle; the next unit gives 001 with mile_wrap=0.
- Drive 2 cycles, moving=0 for 10 cycles, moving=1 -> the increment arrives after 2 more edges (prescaler held); same result using mode=00 as the stop.
- At mile=057 with prescaler at terminal count, assert clear -> mile=000, no mile_tick; repeat with power=0 instead -> mile=000, prescaler cleared (next increment takes a full 4 cycles).
- Assert rst=0 asynchronously mid-count at mile=123 -> mile=000 and all pulses 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/mile_bcd_counter_if.sv
// ---------------------------------------------------------------------------
// mile_bcd_counter_if
// Bundle of the drive-state inputs and mileage outputs of mile_bcd_counter.
//   power      : car power, 0 = off
//   mode[1:0]  : drive mode, 2'b00 = not in drive
//   moving     : 1 while the car is travelling
//   clear      : synchronous mileage clear, active-high
//   mile[11:0] : packed BCD mileage {hundreds, tens, units}
//   mile_tick  : one-cycle pulse per mileage increment
//   mile_wrap  : one-cycle pulse on 999 -> 000
// slave  = counter side, master = driver/observer side.
// ---------------------------------------------------------------------------
interface mile_bcd_counter_if;
    logic        power;
    logic [1:0]  mode;
    logic        moving;
    logic        clear;
    logic [11:0] mile;
    logic        mile_tick;
    logic        mile_wrap;

    modport slave  (input  power, mode, moving, clear,
                    output mile, mile_tick, mile_wrap);
    modport master (output power, mode, moving, clear,
                    input  mile, mile_tick, mile_wrap);
endinterface

// File: rtl/mile_bcd_counter.sv
// ---------------------------------------------------------------------------
// mile_bcd_counter
// Accumulates drive time while powered, in drive mode and moving, and presents
// the distance as a 3-digit packed BCD mileage word for the VGA status display.
// A prescaler turns UNIT_CYCLES clocks of driving into one mileage unit.
//   clk : system clock
//   rst : asynchronous reset, active-low
//   bus : mile_bcd_counter_if.slave (power, mode, moving, clear in;
//         mile, mile_tick, mile_wrap out, all registered)
// ---------------------------------------------------------------------------
module mile_bcd_counter #(
    parameter int unsigned UNIT_CYCLES = 100000000,
    parameter int unsigned PRE_W       = 27
) (
    input  logic                 clk,
    input  logic                 rst,
    mile_bcd_counter_if.slave    bus
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(UNIT_CYCLES - 1);

    logic [PRE_W-1:0] pre_q,   pre_d;
    logic [3:0]       hund_q,  hund_d;
    logic [3:0]       tens_q,  tens_d;
    logic [3:0]       units_q, units_d;
    logic             tick_q,  tick_d;
    logic             wrap_q,  wrap_d;
    logic             count_en;

    assign count_en = bus.power & bus.moving & (bus.mode != 2'b00);

    always_comb begin
        pre_d   = pre_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        units_d = units_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;

        if (!bus.power) begin
            pre_d   = '0;
            hund_d  = '0;
            tens_d  = '0;
            units_d = '0;
        end else if (bus.clear) begin
            // clear wins over a terminal-count increment in the same cycle
            pre_d   = '0;
            hund_d  = '0;
            tens_d  = '0;
            units_d = '0;
        end else if (count_en) begin
            if (pre_q == PRE_LAST) begin
                pre_d  = '0;
                tick_d = 1'b1;
                // BCD ripple: each digit rolls 9 -> 0 and carries upward
                if (units_q == 4'd9) begin
                    units_d = '0;
                    if (tens_q == 4'd9) begin
                        tens_d = '0;
                        if (hund_q == 4'd9) begin
                            hund_d = '0;
                            wrap_d = 1'b1;
                        end else begin
                            hund_d = hund_q + 4'd1;
                        end
                    end else begin
                        tens_d = tens_q + 4'd1;
                    end
                end else begin
                    units_d = units_q + 4'd1;
                end
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
        // powered but stopped: prescaler holds its partial distance
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q   <= '0;
            hund_q  <= '0;
            tens_q  <= '0;
            units_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            units_q <= units_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.mile      = {hund_q, tens_q, units_q};
    assign bus.mile_tick = tick_q;
    assign bus.mile_wrap = wrap_q;

endmodule

// File: tb/tb_mile_bcd_counter.sv
// ---------------------------------------------------------------------------
// tb_mile_bcd_counter
// Self-checking bench for mile_bcd_counter with UNIT_CYCLES=4. A reference
// model keeps mileage as a plain integer 0..999 and drive time as an integer
// count of cycles; expected BCD is derived by decimal division.
// ---------------------------------------------------------------------------
module tb_mile_bcd_counter;

    localparam int UC = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    mile_bcd_counter_if bus();

    mile_bcd_counter #(.UNIT_CYCLES(UC), .PRE_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int m_mile = 0;
    int m_time = 0;
    bit m_tick = 1'b0;
    bit m_wrap = 1'b0;

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h, t, u;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {h, t, u};
    endfunction

    task automatic model_reset();
        m_mile = 0; m_time = 0; m_tick = 1'b0; m_wrap = 1'b0;
    endtask

    // Apply the rules to the inputs present at this edge.
    task automatic model_edge();
        m_tick = 1'b0;
        m_wrap = 1'b0;
        if (!bus.power || bus.clear) begin
            m_mile = 0;
            m_time = 0;
        end else if (bus.moving && bus.mode != 2'b00) begin
            m_time = m_time + 1;
            if (m_time == UC) begin
                m_time = 0;
                m_wrap = (m_mile == 999);
                m_mile = (m_mile + 1) % 1000;
                m_tick = 1'b1;
            end
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit pw, input logic [1:0] md, input bit mv, input bit cl);
        bus.power = pw; bus.mode = md; bus.moving = mv; bus.clear = cl;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        drive(1'b1, 2'b01, 1'b1, 1'b0);
        #12;
        n_checks++;
        if (bus.mile !== 12'h000 || bus.mile_tick !== 1'b0 || bus.mile_wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: mile=%h tick=%b wrap=%b, required 000 0 0", bus.mile, bus.mile_tick, bus.mile_wrap);
        end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_first_unit();
        for (int i = 1; i <= 8; i++) begin
            clk_step();
            n_checks++;
            if (bus.mile !== to_bcd(m_mile) || bus.mile_tick !== m_tick || bus.mile_wrap !== m_wrap) begin
                n_fail++;
                $display("FAIL first_unit edge %0d: mile=%h tick=%b wrap=%b, required %h %b %b", i, bus.mile, bus.mile_tick, bus.mile_wrap, to_bcd(m_mile), m_tick, m_wrap);
            end
            if (i == 3 || i == 4 || i == 8) begin
                n_checks++;
                if ((i == 3 && (bus.mile !== 12'h000 || bus.mile_tick !== 1'b0)) ||
                    (i == 4 && (bus.mile !== 12'h001 || bus.mile_tick !== 1'b1)) ||
                    (i == 8 && (bus.mile !== 12'h002 || bus.mile_tick !== 1'b1))) begin
                    n_fail++;
                    $display("FAIL first_unit latency edge %0d: mile=%h tick=%b", i, bus.mile, bus.mile_tick);
                end
            end
        end
    endtask

    task automatic test_bcd_carry();
        int ticks = 0;
        int start = m_mile;
        int guard = 0;
        while (m_mile != 100 && guard < 1000) begin
            clk_step();
            guard++;
            if (bus.mile_tick === 1'b1) ticks++;
            n_checks++;
            if (bus.mile !== to_bcd(m_mile) || bus.mile_tick !== m_tick || bus.mile_wrap !== m_wrap) begin
                n_fail++;
                $display("FAIL bcd_carry: mile=%h tick=%b wrap=%b, required %h %b %b", bus.mile, bus.mile_tick, bus.mile_wrap, to_bcd(m_mile), m_tick, m_wrap);
            end
            if (bus.mile[3:0] > 4'd9 || bus.mile[7:4] > 4'd9 || bus.mile[11:8] > 4'd9) begin
                n_fail++;
                $display("FAIL bcd_nibble: mile=%h, required every nibble 0..9", bus.mile);
            end
        end
        n_checks++;
        if (m_mile != 100 || ticks != 100 - start) begin
            n_fail++;
            $display("FAIL bcd_tick_count: ticks=%0d mile=%0d, required ticks=%0d mile=100", ticks, m_mile, 100 - start);
        end
    endtask

    task automatic test_wrap();
        int guard = 0;
        while (m_mile != 999 && guard < 5000) begin
            clk_step();
            guard++;
            n_checks++;
            if (bus.mile !== to_bcd(m_mile) || bus.mile_tick !== m_tick || bus.mile_wrap !== m_wrap) begin
                n_fail++;
                $display("FAIL run_to_999: mile=%h tick=%b wrap=%b, required %h %b %b", bus.mile, bus.mile_tick, bus.mile_wrap, to_bcd(m_mile), m_tick, m_wrap);
            end
        end
        n_checks++;
        if (m_mile != 999) begin
            n_fail++;
            $display("FAIL run_to_999 timeout: model mile=%0d, required 999", m_mile);
        end
        for (int i = 1; i <= 2 * UC; i++) begin
            clk_step();
            n_checks++;
            if (bus.mile !== to_bcd(m_mile) || bus.mile_tick !== m_tick || bus.mile_wrap !== m_wrap) begin
                n_fail++;
                $display("FAIL wrap: mile=%h tick=%b wrap=%b, required %h %b %b", bus.mile, bus.mile_tick, bus.mile_wrap, to_bcd(m_mile), m_tick, m_wrap);
            end
        end
        n_checks++;
        if (bus.mile !== 12'h001 || bus.mile_wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL post_wrap: mile=%h wrap=%b, required 001 0", bus.mile, bus.mile_wrap);
        end
    endtask

    task automatic test_stop_hold(input bit use_mode);
        drive(1'b1, 2'b01, 1'b1, 1'b1);
        clk_step();
        bus.clear = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (i == 2) begin
                if (use_mode) bus.mode = 2'b00; else bus.moving = 1'b0;
            end
            if (i == 12) begin
                bus.mode = 2'b10; bus.moving = 1'b1;
            end
            clk_step();
            n_checks++;
            if (bus.mile !== to_bcd(m_mile) || bus.mile_tick !== m_tick || bus.mile_wrap !== m_wrap) begin
                n_fail++;
                $display("FAIL stop_hold(mode=%0b) step %0d: mile=%h tick=%b, required %h %b", use_mode, i, bus.mile, bus.mile_tick, to_bcd(m_mile), m_tick);
            end
            if (i == 12 || i == 13) begin
                n_checks++;
                if ((i == 12 && (bus.mile !== 12'h000 || bus.mile_tick !== 1'b0)) ||
                    (i == 13 && (bus.mile !== 12'h001 || bus.mile_tick !== 1'b1))) begin
                    n_fail++;
                    $display("FAIL stop_resume(mode=%0b) step %0d: mile=%h tick=%b", use_mode, i, bus.mile, bus.mile_tick);
                end
            end
        end
    endtask

    task automatic test_clear_power(input bit use_power);
        int guard = 0;
        drive(1'b1, 2'b11, 1'b1, 1'b1);
        clk_step();
        bus.clear = 1'b0;
        while (m_mile != 57 && guard < 400) begin
            clk_step();
            guard++;
        end
        for (int i = 0; i < UC - 1; i++) clk_step();
        // prescaler now at terminal count with mile=057
        n_checks++;
        if (bus.mile !== 12'h057) begin
            n_fail++;
            $display("FAIL clear_setup: mile=%h, required 057", bus.mile);
        end
        if (use_power) bus.power = 1'b0; else bus.clear = 1'b1;
        clk_step();
        n_checks++;
        if (bus.mile !== 12'h000 || bus.mile_tick !== 1'b0 || bus.mile_wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL clear(power=%0b): mile=%h tick=%b wrap=%b, required 000 0 0", use_power, bus.mile, bus.mile_tick, bus.mile_wrap);
        end
        bus.power = 1'b1; bus.clear = 1'b0;
        for (int i = 1; i <= UC; i++) begin
            clk_step();
            n_checks++;
            if (bus.mile !== to_bcd(m_mile) || bus.mile_tick !== m_tick ||
                (i < UC && bus.mile_tick !== 1'b0) || (i == UC && bus.mile !== 12'h001)) begin
                n_fail++;
                $display("FAIL after_clear(power=%0b) edge %0d: mile=%h tick=%b, required %h %b", use_power, i, bus.mile, bus.mile_tick, to_bcd(m_mile), m_tick);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            bus.power  = ($urandom_range(0, 31) != 0);
            bus.clear  = ($urandom_range(0, 63) == 0);
            bus.mode   = 2'($urandom_range(0, 3));
            bus.moving = ($urandom_range(0, 3) != 0);
            clk_step();
            n_checks++;
            if (bus.mile !== to_bcd(m_mile) || bus.mile_tick !== m_tick || bus.mile_wrap !== m_wrap) begin
                n_fail++;
                $display("FAIL random cycle %0d: mile=%h tick=%b wrap=%b, required %h %b %b", i, bus.mile, bus.mile_tick, bus.mile_wrap, to_bcd(m_mile), m_tick, m_wrap);
            end
        end
    endtask

    task automatic test_async_reset();
        int guard = 0;
        drive(1'b1, 2'b01, 1'b1, 1'b1);
        clk_step();
        bus.clear = 1'b0;
        while (m_mile != 123 && guard < 600) begin
            clk_step();
            guard++;
        end
        n_checks++;
        if (bus.mile !== 12'h123 || bus.mile_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL async_setup: mile=%h tick=%b, required 123 1", bus.mile, bus.mile_tick);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.mile !== 12'h000 || bus.mile_tick !== 1'b0 || bus.mile_wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: mile=%h tick=%b wrap=%b, required 000 0 0", bus.mile, bus.mile_tick, bus.mile_wrap);
        end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 1; i <= UC; i++) begin
            clk_step();
            n_checks++;
            if (bus.mile !== to_bcd(m_mile) || bus.mile_tick !== m_tick) begin
                n_fail++;
                $display("FAIL after_async: mile=%h tick=%b, required %h %b", bus.mile, bus.mile_tick, to_bcd(m_mile), m_tick);
            end
        end
    endtask

    initial begin
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        test_reset();
        test_first_unit();
        test_bcd_carry();
        test_wrap();
        test_stop_hold(1'b0);
        test_stop_hold(1'b1);
        test_clear_power(1'b0);
        test_clear_power(1'b1);
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
